// File: rtl/dma_load_ctrl_pkg.sv
// Shared definitions for the DMA load sequencer and the opcode decoder feeding it.
package dma_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dma_state_t;

  // Opcode encodings used by the upstream decoder to raise each strobe.
  localparam logic [3:0] OP_FETCH_W   = 4'b0001;
  localparam logic [3:0] OP_FETCH_INP = 4'b0010;
  localparam logic [3:0] OP_FETCH_INS = 4'b0011;
  localparam logic [3:0] OP_START     = 4'b0100;

endpackage

// File: rtl/dma_load_ctrl_rise_detect.sv
// Single-bit rising-edge detector. The history register tracks the strobe
// every cycle, so a held level produces exactly one event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  // Track last-cycle value of the strobe.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/dma_load_ctrl.sv
// Load sequencer: turns decoder strobes into single buffer write cycles,
// counts loads per buffer, gates the compute start and blocks loads in RUN.
//
// state | meaning
// IDLE  | accepting buffer writes and start requests
// RUN   | core computing; all strobe events discarded until core_done
module dma_load_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_w,
  input  logic              fetch_inp,
  input  logic              fetch_ins,
  input  logic              start,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              core_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              w_we,
  output logic              inp_we,
  output logic              ins_we,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err_start,
  output logic [CNT_W-1:0]  w_count,
  output logic [CNT_W-1:0]  inp_count,
  output logic [CNT_W-1:0]  ins_count
);

  // Counters saturate at the buffer depth.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dma_state_t state;
  logic       w_rise;
  logic       inp_rise;
  logic       ins_rise;
  logic       start_rise;
  logic       all_loaded;

  rise_detect u_rd_w (
    .clk   (clk),
    .reset (reset),
    .sig   (fetch_w),
    .rise  (w_rise)
  );

  rise_detect u_rd_inp (
    .clk   (clk),
    .reset (reset),
    .sig   (fetch_inp),
    .rise  (inp_rise)
  );

  rise_detect u_rd_ins (
    .clk   (clk),
    .reset (reset),
    .sig   (fetch_ins),
    .rise  (ins_rise)
  );

  rise_detect u_rd_start (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .rise  (start_rise)
  );

  assign all_loaded = (w_count != '0) && (inp_count != '0) && (ins_count != '0);

  // Sequencer FSM with write port, counters and status flags all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_data   <= '0;
      w_we       <= 1'b0;
      inp_we     <= 1'b0;
      ins_we     <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_start  <= 1'b0;
      w_count    <= '0;
      inp_count  <= '0;
      ins_count  <= '0;
    end else begin
      w_we       <= 1'b0;
      inp_we     <= 1'b0;
      ins_we     <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (w_rise) begin
            mem_addr <= dma_address;
            mem_data <= data_in;
            w_we     <= 1'b1;
            if (w_count != CNT_MAX) w_count <= w_count + CNT_ONE;
          end else if (inp_rise) begin
            mem_addr <= dma_address;
            mem_data <= data_in;
            inp_we   <= 1'b1;
            if (inp_count != CNT_MAX) inp_count <= inp_count + CNT_ONE;
          end else if (ins_rise) begin
            mem_addr <= dma_address;
            mem_data <= data_in;
            ins_we   <= 1'b1;
            if (ins_count != CNT_MAX) ins_count <= ins_count + CNT_ONE;
          end else if (start_rise) begin
            if (all_loaded) begin
              state      <= RUN;
              busy       <= 1'b1;
              core_start <= 1'b1;
            end else begin
              err_start <= 1'b1;
            end
          end
        end
        RUN: begin
          // core_start still high marks the launch cycle; core_done is not
          // trusted until the core has actually seen the start pulse.
          if (core_done && !core_start) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_load_ctrl.sv
// Testbench for dma_load_ctrl: directed vector table, hand sequences for
// hold/saturation/reset corners, and randomized traffic against a model.
module tb_dma_load_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_w, fetch_inp, fetch_ins, start;
  logic [5:0] dma_address;
  logic [7:0] data_in;
  logic       core_done;
  logic [5:0] mem_addr;
  logic [7:0] mem_data;
  logic       w_we, inp_we, ins_we, core_start, busy, done, err_start;
  logic [6:0] w_count, inp_count, ins_count;

  int n_cmp = 0;
  int n_bad = 0;

  dma_load_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_w     (fetch_w),
    .fetch_inp   (fetch_inp),
    .fetch_ins   (fetch_ins),
    .start       (start),
    .dma_address (dma_address),
    .data_in     (data_in),
    .core_done   (core_done),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .w_we        (w_we),
    .inp_we      (inp_we),
    .ins_we      (ins_we),
    .core_start  (core_start),
    .busy        (busy),
    .done        (done),
    .err_start   (err_start),
    .w_count     (w_count),
    .inp_count   (inp_count),
    .ins_count   (ins_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic       m_run, m_cs, m_done, m_err;
  logic [2:0] m_we;
  logic [5:0] m_addr;
  logic [7:0] m_data;
  int         m_cnt[3];
  logic       p_str[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cs = 0; m_done = 0; m_err = 0; m_we = '0;
    m_addr = '0; m_data = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    for (int i = 0; i < 4; i++) p_str[i] = 0;
  endtask

  // Advance model and DUT one clock, then compare every output.
  task automatic step();
    logic cur[4];
    logic ev[4];
    logic launch_cycle;
    cur[0] = fetch_w; cur[1] = fetch_inp; cur[2] = fetch_ins; cur[3] = start;
    for (int i = 0; i < 4; i++) ev[i] = cur[i] & ~p_str[i];
    if (reset) begin
      model_reset();
    end else begin
      launch_cycle = m_cs;
      m_we = '0; m_cs = 0; m_done = 0;
      if (!m_run) begin
        if (ev[0] || ev[1] || ev[2]) begin
          for (int b = 0; b < 3; b++)
            if (ev[b]) begin
              m_we[b]  = 1'b1;
              m_cnt[b] = (m_cnt[b] + 1 > 64) ? 64 : m_cnt[b] + 1;
            end
          m_addr = dma_address;
          m_data = data_in;
        end else if (ev[3]) begin
          if (m_cnt[0] > 0 && m_cnt[1] > 0 && m_cnt[2] > 0) begin
            m_run = 1; m_cs = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (core_done && !launch_cycle) begin
        m_run = 0; m_done = 1;
      end
      for (int i = 0; i < 4; i++) p_str[i] = cur[i];
    end
    @(posedge clk);
    #1;
    check("w_we",       32'(w_we),       32'(m_we[0]));
    check("inp_we",     32'(inp_we),     32'(m_we[1]));
    check("ins_we",     32'(ins_we),     32'(m_we[2]));
    check("core_start", 32'(core_start), 32'(m_cs));
    check("busy",       32'(busy),       32'(m_run));
    check("done",       32'(done),       32'(m_done));
    check("err_start",  32'(err_start),  32'(m_err));
    check("mem_addr",   32'(mem_addr),   32'(m_addr));
    check("mem_data",   32'(mem_data),   32'(m_data));
    check("w_count",    32'(w_count),    32'(m_cnt[0]));
    check("inp_count",  32'(inp_count),  32'(m_cnt[1]));
    check("ins_count",  32'(ins_count),  32'(m_cnt[2]));
  endtask

  task automatic idle_inputs();
    fetch_w = 0; fetch_inp = 0; fetch_ins = 0; start = 0; core_done = 0;
  endtask

  typedef struct {
    logic       fw, fi, fs, st, cd;
    logic [5:0] a;
    logic [7:0] d;
    logic [2:0] we;      // {ins, inp, w}
    logic       cs, bs, dn, er;
    logic [5:0] ma;
    logic [7:0] md;
    logic [6:0] wc, ic, sc;
  } vec_t;

  function automatic vec_t mk(input logic fw, fi, fs, st, cd, input logic [5:0] a,
                              input logic [7:0] d, input logic [2:0] we,
                              input logic cs, bs, dn, er, input logic [5:0] ma,
                              input logic [7:0] md, input logic [6:0] wc, ic, sc);
    vec_t v;
    v.fw = fw; v.fi = fi; v.fs = fs; v.st = st; v.cd = cd; v.a = a; v.d = d;
    v.we = we; v.cs = cs; v.bs = bs; v.dn = dn; v.er = er;
    v.ma = ma; v.md = md; v.wc = wc; v.ic = ic; v.sc = sc;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int pulses;
    int sel;

    //             fw fi fs st cd  a   d      we    cs bs dn er ma  md     wc ic sc
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 8'hA3, 3'b001, 0, 0, 0, 0, 5, 8'hA3, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 5, 8'hA3, 3'b000, 0, 0, 0, 0, 5, 8'hA3, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 1, 8'h00, 3'b000, 0, 0, 0, 1, 5, 8'hA3, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 3'b000, 0, 0, 0, 1, 5, 8'hA3, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 3, 8'h11, 3'b010, 0, 0, 0, 1, 3, 8'h11, 1, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 3, 8'h11, 3'b000, 0, 0, 0, 1, 3, 8'h11, 1, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 3, 8'h11, 3'b000, 0, 0, 0, 1, 3, 8'h11, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 3, 8'h11, 3'b000, 0, 0, 0, 1, 3, 8'h11, 1, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 7, 8'h22, 3'b100, 0, 0, 0, 1, 7, 8'h22, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 1, 0, 7, 8'h22, 3'b000, 1, 1, 0, 1, 7, 8'h22, 1, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 7, 8'h22, 3'b000, 0, 1, 0, 1, 7, 8'h22, 1, 1, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 9, 8'h44, 3'b000, 0, 1, 0, 1, 7, 8'h22, 1, 1, 1);
    tbl[12] = mk(0, 0, 0, 1, 0, 9, 8'h44, 3'b000, 0, 1, 0, 1, 7, 8'h22, 1, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 1, 9, 8'h44, 3'b000, 0, 0, 1, 1, 7, 8'h22, 1, 1, 1);
    tbl[14] = mk(1, 0, 0, 0, 0, 9, 8'h44, 3'b001, 0, 0, 0, 1, 9, 8'h44, 2, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 9, 8'h44, 3'b000, 0, 0, 0, 1, 9, 8'h44, 2, 1, 1);

    model_reset();
    idle_inputs();
    dma_address = '0; data_in = '0;
    reset = 1;
    #1;
    step();
    step();
    reset = 0;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      fetch_w = tbl[i].fw; fetch_inp = tbl[i].fi; fetch_ins = tbl[i].fs;
      start = tbl[i].st; core_done = tbl[i].cd;
      dma_address = tbl[i].a; data_in = tbl[i].d;
      step();
      check("tbl_we",    32'({ins_we, inp_we, w_we}), 32'(tbl[i].we));
      check("tbl_cs",    32'(core_start), 32'(tbl[i].cs));
      check("tbl_busy",  32'(busy),       32'(tbl[i].bs));
      check("tbl_done",  32'(done),       32'(tbl[i].dn));
      check("tbl_err",   32'(err_start),  32'(tbl[i].er));
      check("tbl_addr",  32'(mem_addr),   32'(tbl[i].ma));
      check("tbl_data",  32'(mem_data),   32'(tbl[i].md));
      check("tbl_wcnt",  32'(w_count),    32'(tbl[i].wc));
      check("tbl_icnt",  32'(inp_count),  32'(tbl[i].ic));
      check("tbl_scnt",  32'(ins_count),  32'(tbl[i].sc));
    end

    // Strobe held high for 10 cycles yields one write
    idle_inputs();
    step();
    pulses = 0;
    fetch_inp = 1; dma_address = 6'd3; data_in = 8'h5C;
    for (int i = 0; i < 10; i++) begin
      step();
      if (inp_we) pulses++;
    end
    fetch_inp = 0;
    step();
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_icnt",   32'(inp_count), 32'd2);

    // Saturation: 65 weight writes after a fresh reset
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 65; i++) begin
      fetch_w = 1; dma_address = 6'(i); data_in = 8'(i * 3);
      step();
      check("sat_we", 32'(w_we), 32'd1);
      fetch_w = 0;
      step();
    end
    check("sat_wcnt", 32'(w_count), 32'd64);
    check("sat_addr", 32'(mem_addr), 32'd0);

    // Reset during RUN: no done pulse, everything cleared
    fetch_inp = 1; step(); fetch_inp = 0; step();
    fetch_ins = 1; step(); fetch_ins = 0; step();
    start = 1; step(); start = 0;
    check("run_busy", 32'(busy), 32'd1);
    step();
    reset = 1; core_done = 1;
    step();
    reset = 0; core_done = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wcnt", 32'(w_count), 32'd0);
    step();

    // Randomized traffic against the model
    sel = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) sel = int'($urandom_range(0, 5));
      fetch_w   = (sel == 1);
      fetch_inp = (sel == 2);
      fetch_ins = (sel == 3);
      start     = (sel == 4) || (sel == 5);
      core_done = ($urandom_range(0, 6) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      dma_address = 6'($urandom);
      data_in     = 8'($urandom);
      step();
    end
    reset = 0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
